// File: rtl/wb_trace_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_trace_buffer_if
//  Description : Writeback-lane observation bundle. The pipeline side drives
//                it and the trace buffer only listens.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_trace_buffer_if #(
    parameter int NUM_WB = 4,
    parameter int AL_W   = 5
);
    logic [NUM_WB-1:0]           i_wb_valid;
    logic [NUM_WB-1:0]           i_wb_uses_rd;
    logic [NUM_WB-1:0][4:0]      i_wb_rd;
    logic [NUM_WB-1:0][AL_W-1:0] i_wb_al_idx;
    logic [NUM_WB-1:0][31:0]     i_wb_data;

    modport master (
        output i_wb_valid, i_wb_uses_rd, i_wb_rd, i_wb_al_idx, i_wb_data
    );

    modport slave (
        input  i_wb_valid, i_wb_uses_rd, i_wb_rd, i_wb_al_idx, i_wb_data
    );
endinterface
`default_nettype wire

// File: rtl/wb_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : wb_trace_buffer
//  Description : Records writeback events from the four wb lanes into an
//                on-chip trace buffer and lets the operator step through it
//                16 bits at a time via sel/step and the LED bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_trace_buffer #(
    parameter int DEPTH  = 64,
    parameter int AL_W   = 5,
    parameter int NUM_WB = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    arm,
    input  logic                    step,
    input  logic [3:0]              sel,
    wb_trace_buffer_if.slave        wb,
    output logic [15:0]             r_out,
    output logic                    capturing,
    output logic                    full
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = c_ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_FROZEN  = 2'd2
    } state_t;

    typedef struct packed {
        logic [15:0]     ts;
        logic            uses_rd;
        logic [1:0]      lane;
        logic [4:0]      rd;
        logic [AL_W-1:0] al_idx;
        logic [31:0]     data;
    } entry_t;

    state_t               state_q, state_d;
    logic [c_CNT_W-1:0]   count_q, count_d;
    logic [c_ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [15:0]          overflow_cnt_q, overflow_cnt_d;
    logic [15:0]          timestamp_q, timestamp_d;
    logic [15:0]          r_out_q, r_out_d;
    logic [2:0]           arm_sync_q, arm_sync_d;
    logic [2:0]           step_sync_q, step_sync_d;

    entry_t               trace_mem [DEPTH];

    logic                 w_arm_p, w_step_p, w_arm_s, w_cap_en, w_full;
    logic [NUM_WB-1:0]    w_we;
    logic [c_CNT_W-1:0]   w_slot [NUM_WB];
    entry_t               w_entry [NUM_WB];
    logic [2:0]           w_written, w_dropped;
    logic [16:0]          w_ovf_sum;
    entry_t               w_rd_entry;
    logic                 w_rd_ok;

    // Two-flop synchronisers plus a third stage for rising-edge detection
    always_comb begin
        arm_sync_d  = {arm_sync_q[1:0], arm};
        step_sync_d = {step_sync_q[1:0], step};
    end

    // Synchroniser flops are not reset so a switch held through reset is not seen as a new edge
    always_ff @(posedge clk) begin
        arm_sync_q  <= arm_sync_d;
        step_sync_q <= step_sync_d;
    end

    assign w_arm_s  = arm_sync_q[1];
    assign w_arm_p  = arm_sync_q[1] & ~arm_sync_q[2];
    assign w_step_p = step_sync_q[1] & ~step_sync_q[2];
    assign w_full   = (count_q == c_CNT_W'(DEPTH));
    assign w_cap_en = (state_q == S_CAPTURE) && !w_arm_p;

    // Pack valid lanes in lane order into consecutive slots; slots past the end are dropped
    always_comb begin
        logic [2:0] run;
        run       = '0;
        w_we      = '0;
        w_written = '0;
        w_dropped = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            w_slot[k]          = count_q + c_CNT_W'(run);
            w_entry[k].ts      = timestamp_q;
            w_entry[k].uses_rd = wb.i_wb_uses_rd[k];
            w_entry[k].lane    = 2'(k);
            w_entry[k].rd      = wb.i_wb_rd[k];
            w_entry[k].al_idx  = wb.i_wb_al_idx[k];
            w_entry[k].data    = wb.i_wb_data[k];
            if (w_cap_en && wb.i_wb_valid[k]) begin
                run = run + 3'd1;
                if (w_slot[k] < c_CNT_W'(DEPTH)) begin
                    w_we[k]   = 1'b1;
                    w_written = w_written + 3'd1;
                end else begin
                    w_dropped = w_dropped + 3'd1;
                end
            end
        end
    end

    // Trace RAM write ports, one per lane; contents are intentionally not reset
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_WB; k++) begin
            if (w_we[k]) begin
                trace_mem[w_slot[k][c_ADDR_W-1:0]] <= w_entry[k];
            end
        end
    end

    assign w_ovf_sum = {1'b0, overflow_cnt_q} + 17'(w_dropped);

    // Capture FSM, counters and read pointer; an arm edge restarts from any state and beats step
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        rd_ptr_d       = rd_ptr_q;
        overflow_cnt_d = overflow_cnt_q;
        timestamp_d    = timestamp_q;
        if (w_arm_p) begin
            state_d        = S_CAPTURE;
            count_d        = '0;
            rd_ptr_d       = '0;
            overflow_cnt_d = '0;
            timestamp_d    = '0;
        end else begin
            if (state_q == S_CAPTURE) begin
                count_d        = count_q + c_CNT_W'(w_written);
                overflow_cnt_d = w_ovf_sum[16] ? 16'hFFFF : w_ovf_sum[15:0];
                timestamp_d    = timestamp_q + 16'd1;
                if (!w_arm_s || (count_d == c_CNT_W'(DEPTH))) begin
                    state_d = S_FROZEN;
                end
            end
            if (w_step_p) begin
                if (count_q == '0) begin
                    rd_ptr_d = '0;
                end else if ({1'b0, rd_ptr_q} == (count_q - c_CNT_W'(1))) begin
                    rd_ptr_d = '0;
                end else begin
                    rd_ptr_d = rd_ptr_q + c_ADDR_W'(1);
                end
            end
        end
    end

    // Readout mux; entry fields read as zero when the pointer is beyond the captured data
    always_comb begin
        w_rd_entry = trace_mem[rd_ptr_q];
        w_rd_ok    = ({1'b0, rd_ptr_q} < count_q);
        r_out_d    = '0;
        case (sel)
            4'd0: if (w_rd_ok) r_out_d = w_rd_entry.data[15:0];
            4'd1: if (w_rd_ok) r_out_d = w_rd_entry.data[31:16];
            4'd2: if (w_rd_ok) r_out_d = {w_rd_entry.uses_rd, w_rd_entry.lane,
                                          w_rd_entry.rd, 8'(w_rd_entry.al_idx)};
            4'd3: if (w_rd_ok) r_out_d = w_rd_entry.ts;
            4'd4: r_out_d = 16'(count_q);
            4'd5: r_out_d = overflow_cnt_q;
            4'd6: r_out_d = 16'(rd_ptr_q);
            4'd7: r_out_d = {13'b0, w_full, state_q};
            default: r_out_d = '0;
        endcase
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            count_q        <= '0;
            rd_ptr_q       <= '0;
            overflow_cnt_q <= '0;
            timestamp_q    <= '0;
            r_out_q        <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            rd_ptr_q       <= rd_ptr_d;
            overflow_cnt_q <= overflow_cnt_d;
            timestamp_q    <= timestamp_d;
            r_out_q        <= r_out_d;
        end
    end

    assign r_out     = r_out_q;
    assign capturing = (state_q == S_CAPTURE);
    assign full      = w_full;

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_wb_trace_buffer
//  Description : Self-checking bench for wb_trace_buffer: directed scenarios
//                plus randomized traffic against a queue-based trace model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_trace_buffer;

    localparam int DEPTH  = 64;
    localparam int AL_W   = 5;
    localparam int NUM_WB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        arm = 1'b0;
    logic        step = 1'b0;
    logic [3:0]  sel = 4'd0;
    logic [15:0] r_out;
    logic        capturing;
    logic        full;

    wb_trace_buffer_if #(.NUM_WB(NUM_WB), .AL_W(AL_W)) wb_if ();

    wb_trace_buffer #(.DEPTH(DEPTH), .AL_W(AL_W), .NUM_WB(NUM_WB)) dut (
        .clk       (clk),
        .reset     (reset),
        .arm       (arm),
        .step      (step),
        .sel       (sel),
        .wb        (wb_if),
        .r_out     (r_out),
        .capturing (capturing),
        .full      (full)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0]     ts;
        logic            uses;
        logic [1:0]      lane;
        logic [4:0]      rd;
        logic [AL_W-1:0] al;
        logic [31:0]     data;
    } ent_t;

    ent_t        mq[$];
    int          m_state = 0;   // 0 idle, 1 capture, 2 frozen
    int          m_rd = 0;
    int          m_ovf = 0;
    int          m_ts = 0;
    logic [15:0] m_rout = '0;
    bit          arm_hist[$]  = '{0, 0, 0};  // [i] = raw value i+1 cycles ago
    bit          step_hist[$] = '{0, 0, 0};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] m_field(input logic [3:0] s);
        int   n;
        ent_t e;
        n = mq.size();
        if (s <= 4'd3) begin
            if (m_rd >= n) return 16'h0;
            e = mq[m_rd];
            case (s)
                4'd0: return e.data[15:0];
                4'd1: return e.data[31:16];
                4'd2: return {e.uses, e.lane, e.rd, 8'(e.al)};
                default: return e.ts;
            endcase
        end
        case (s)
            4'd4: return 16'(n);
            4'd5: return 16'(m_ovf);
            4'd6: return 16'(m_rd);
            4'd7: return {13'b0, (n == DEPTH), 2'(m_state)};
            default: return 16'h0;
        endcase
    endfunction

    // Advance the model by one clock using the inputs currently applied
    task automatic model_cycle();
        bit   ap, sp, a_sync;
        int   n0;
        ent_t e;
        ap     = arm_hist[1] && !arm_hist[2];
        sp     = step_hist[1] && !step_hist[2];
        a_sync = arm_hist[1];
        if (reset) begin
            m_state = 0; mq.delete(); m_rd = 0; m_ovf = 0; m_ts = 0; m_rout = '0;
        end else begin
            m_rout = m_field(sel);
            n0 = mq.size();
            if (ap) begin
                m_state = 1; mq.delete(); m_rd = 0; m_ovf = 0; m_ts = 0;
            end else begin
                if (m_state == 1) begin
                    for (int k = 0; k < NUM_WB; k++) begin
                        if (wb_if.i_wb_valid[k]) begin
                            if (mq.size() < DEPTH) begin
                                e.ts = 16'(m_ts); e.uses = wb_if.i_wb_uses_rd[k];
                                e.lane = 2'(k); e.rd = wb_if.i_wb_rd[k];
                                e.al = wb_if.i_wb_al_idx[k]; e.data = wb_if.i_wb_data[k];
                                mq.push_back(e);
                            end else if (m_ovf < 65535) begin
                                m_ovf++;
                            end
                        end
                    end
                    m_ts = (m_ts + 1) % 65536;
                    if (!a_sync || mq.size() == DEPTH) m_state = 2;
                end
                if (sp) m_rd = (n0 == 0) ? 0 : (m_rd + 1) % n0;
            end
        end
        arm_hist.push_front(arm);   void'(arm_hist.pop_back());
        step_hist.push_front(step); void'(step_hist.pop_back());
    endtask

    task automatic tick();
        model_cycle();
        @(posedge clk);
        #1;
        check("r_out", {16'h0, r_out}, {16'h0, m_rout});
        check("capturing", {31'h0, capturing}, {31'h0, (m_state == 1)});
        check("full", {31'h0, full}, {31'h0, (mq.size() == DEPTH)});
    endtask

    task automatic set_lanes(input logic [3:0] v);
        for (int k = 0; k < NUM_WB; k++) begin
            wb_if.i_wb_uses_rd[k] = 1'($urandom);
            wb_if.i_wb_rd[k]      = 5'($urandom);
            wb_if.i_wb_al_idx[k]  = AL_W'($urandom);
            wb_if.i_wb_data[k]    = $urandom;
        end
        wb_if.i_wb_valid = v;
    endtask

    task automatic read_sel(input logic [3:0] s, output logic [15:0] v);
        sel = s;
        tick();
        v = r_out;
    endtask

    task automatic pulse_step();
        step = 1'b1; tick(); tick();
        step = 1'b0; tick(); tick();
    endtask

    task automatic start_capture();
        set_lanes(4'h0);
        arm = 1'b0; repeat (3) tick();
        arm = 1'b1; repeat (3) tick();
    endtask

    logic [15:0] v;

    initial begin
        set_lanes(4'h0);

        // Reset state
        reset = 1'b1; repeat (3) tick(); reset = 1'b0;
        read_sel(4'd4, v); check("rst_count", {16'h0, v}, 32'h0);
        read_sel(4'd5, v); check("rst_ovf", {16'h0, v}, 32'h0);
        read_sel(4'd7, v); check("rst_status", {16'h0, v}, 32'h0);
        read_sel(4'd0, v); check("rst_data_lo", {16'h0, v}, 32'h0);

        // Step with empty buffer
        pulse_step();
        read_sel(4'd6, v); check("step_empty_rd", {16'h0, v}, 32'h0);

        // Three-entry capture
        start_capture();
        check("cap_active", {31'h0, capturing}, 32'h1);
        set_lanes(4'h0);
        wb_if.i_wb_valid = 4'b0001; wb_if.i_wb_uses_rd[0] = 1'b1;
        wb_if.i_wb_rd[0] = 5'd3; wb_if.i_wb_al_idx[0] = AL_W'(7);
        wb_if.i_wb_data[0] = 32'hDEADBEEF;
        tick();
        set_lanes(4'b1010); tick();
        set_lanes(4'h0); arm = 1'b0; repeat (4) tick();
        read_sel(4'd4, v); check("t3_count", {16'h0, v}, 32'd3);
        read_sel(4'd7, v); check("t3_status", {16'h0, v}, 32'h2);
        read_sel(4'd1, v); check("e0_data_hi", {16'h0, v}, 32'hDEAD);
        read_sel(4'd0, v); check("e0_data_lo", {16'h0, v}, 32'hBEEF);
        read_sel(4'd2, v); check("e0_meta", {16'h0, v}, 32'h8307);
        read_sel(4'd3, v); check("e0_ts", {16'h0, v}, 32'h0);
        pulse_step();
        read_sel(4'd6, v); check("step1_rd", {16'h0, v}, 32'd1);
        read_sel(4'd2, v); check("e1_lane", {30'h0, v[14:13]}, 32'd1);
        read_sel(4'd3, v); check("e1_ts", {16'h0, v}, 32'd1);
        pulse_step();
        read_sel(4'd6, v); check("step2_rd", {16'h0, v}, 32'd2);
        read_sel(4'd2, v); check("e2_lane", {30'h0, v[14:13]}, 32'd3);
        read_sel(4'd3, v); check("e2_ts", {16'h0, v}, 32'd1);
        pulse_step();
        read_sel(4'd6, v); check("step_wrap_rd", {16'h0, v}, 32'd0);

        // Exact fill to DEPTH, then extra traffic after freezing
        start_capture();
        repeat (16) begin set_lanes(4'hF); tick(); end
        set_lanes(4'hF); tick();
        set_lanes(4'h0);
        read_sel(4'd4, v); check("fill_count", {16'h0, v}, 32'd64);
        read_sel(4'd5, v); check("fill_ovf", {16'h0, v}, 32'd0);
        read_sel(4'd7, v); check("fill_status", {16'h0, v}, 32'h6);

        // 62 entries then four lanes: two written, two overflow
        start_capture();
        repeat (15) begin set_lanes(4'hF); tick(); end
        set_lanes(4'b0011); tick();
        set_lanes(4'hF); tick();
        set_lanes(4'h0);
        read_sel(4'd4, v); check("ovf_count", {16'h0, v}, 32'd64);
        read_sel(4'd5, v); check("ovf_cnt", {16'h0, v}, 32'd2);
        read_sel(4'd7, v); check("ovf_status", {16'h0, v}, 32'h6);

        // Coincident arm and step edges: arm wins, timestamp restarts
        pulse_step();
        arm = 1'b0; repeat (3) tick();
        arm = 1'b1; step = 1'b1; repeat (3) tick();
        step = 1'b0;
        set_lanes(4'b0001); tick();
        set_lanes(4'h0);
        read_sel(4'd6, v); check("coinc_rd", {16'h0, v}, 32'd0);
        read_sel(4'd4, v); check("coinc_count", {16'h0, v}, 32'd1);
        read_sel(4'd3, v); check("coinc_ts", {16'h0, v}, 32'd0);

        // Reset in the middle of a capture
        start_capture();
        set_lanes(4'hF); tick(); tick();
        set_lanes(4'b0011); tick();
        set_lanes(4'h0);
        read_sel(4'd4, v); check("mid_count", {16'h0, v}, 32'd10);
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst_mid_capturing", {31'h0, capturing}, 32'h0);
        set_lanes(4'hF);
        read_sel(4'd4, v); check("rst_mid_count", {16'h0, v}, 32'd0);
        repeat (4) tick();
        read_sel(4'd7, v); check("rst_mid_status", {16'h0, v}, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) arm = ~arm;
            if ($urandom_range(0, 2) == 0) step = ~step;
            reset = ($urandom_range(0, 399) == 0);
            sel = 4'($urandom);
            set_lanes(4'($urandom));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
